// File: rtl/div_if.sv
// Handshake and data bundle between the EX stage (master) and the divider (slave).
interface div_if #(
  parameter int DATA_W = 32
);
  logic                  signed_div;
  logic [DATA_W-1:0]     opdata1;
  logic [DATA_W-1:0]     opdata2;
  logic                  start;
  logic                  annul;
  logic [2*DATA_W-1:0]   result;
  logic                  ready;
  logic                  stallreq;

  modport master (
    output signed_div, opdata1, opdata2, start, annul,
    input  result, ready, stallreq
  );

  modport slave (
    input  signed_div, opdata1, opdata2, start, annul,
    output result, ready, stallreq
  );
endinterface

// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring DIV/DIVU, result = {remainder, quotient}.
// Optional feature: define DIV_EARLY_OUT_EN to finish early when |dividend| < |divisor|.
module div_unit #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic clk,
  input  logic resetn,
  div_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BYZERO = 2'd1,
    ON     = 2'd2,
    END    = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W);

  function automatic logic [DATA_W-1:0] apply_sign(input logic [DATA_W-1:0] v,
                                                   input logic              neg);
    if (neg) begin
      return (~v) + DATA_W'(1);
    end else begin
      return v;
    end
  endfunction

  function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v,
                                                  input logic              is_signed);
    return apply_sign(v, is_signed & v[DATA_W-1]);
  endfunction

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    counter_q, counter_d;
  logic [2*DATA_W:0]   work_q, work_d;
  logic [DATA_W-1:0]   divisor_q, divisor_d;
  logic                quot_neg_q, quot_neg_d;
  logic                rem_neg_q, rem_neg_d;
  logic                early_q, early_d;
  logic [2*DATA_W-1:0] result_q, result_d;
  logic                ready_q, ready_d;

  logic [DATA_W-1:0]   op1_abs_s;
  logic [DATA_W-1:0]   op2_abs_s;
  logic [DATA_W+1:0]   trial_s;
  logic [2*DATA_W:0]   step_s;
  logic [DATA_W-1:0]   quot_fin_s;
  logic [DATA_W-1:0]   rem_fin_s;

  // One restoring step: trial-subtract the divisor from the upper partial remainder.
  always_comb begin
    op1_abs_s = magnitude(bus.opdata1, bus.signed_div);
    op2_abs_s = magnitude(bus.opdata2, bus.signed_div);
    trial_s   = {1'b0, work_q[2*DATA_W:DATA_W]} - {2'b00, divisor_q};
    step_s    = {(2*DATA_W+1){1'b0}};
    if (trial_s[DATA_W+1]) begin
      step_s = work_q << 1;
    end else begin
      step_s    = {trial_s[DATA_W:0], work_q[DATA_W-1:0]} << 1;
      step_s[0] = 1'b1;
    end
    quot_fin_s = step_s[DATA_W-1:0];
    rem_fin_s  = step_s[2*DATA_W:DATA_W+1];
  end

  // Next-state and next-datapath logic for the control FSM.
  always_comb begin
    state_d    = state_q;
    counter_d  = counter_q;
    work_d     = work_q;
    divisor_d  = divisor_q;
    quot_neg_d = quot_neg_q;
    rem_neg_d  = rem_neg_q;
    early_d    = early_q;
    result_d   = result_q;
    ready_d    = ready_q;

    case (state_q)
      IDLE: begin
        ready_d  = 1'b0;
        result_d = {(2*DATA_W){1'b0}};
        if (bus.start && !bus.annul) begin
          counter_d  = {CNT_W{1'b0}};
          divisor_d  = op2_abs_s;
          work_d     = {{DATA_W{1'b0}}, op1_abs_s, 1'b0};
          quot_neg_d = bus.signed_div & (bus.opdata1[DATA_W-1] ^ bus.opdata2[DATA_W-1]);
          rem_neg_d  = bus.signed_div & bus.opdata1[DATA_W-1];
          early_d    = 1'b0;
          if (bus.opdata2 == {DATA_W{1'b0}}) begin
            state_d = BYZERO;
          end else begin
`ifdef DIV_EARLY_OUT_EN
            // Early exit shares the one-cycle BYZERO hop so ready lands at N+2.
            if (op1_abs_s < op2_abs_s) begin
              early_d = 1'b1;
              state_d = BYZERO;
            end else begin
              state_d = ON;
            end
`else
            state_d = ON;
`endif
          end
        end else begin
          state_d = IDLE;
        end
      end

      BYZERO: begin
        if (bus.annul) begin
          state_d  = IDLE;
          ready_d  = 1'b0;
          result_d = {(2*DATA_W){1'b0}};
        end else begin
          state_d = END;
          ready_d = 1'b1;
          if (early_q) begin
            result_d = {apply_sign(work_q[DATA_W:1], rem_neg_q), {DATA_W{1'b0}}};
          end else begin
            result_d = {(2*DATA_W){1'b0}};
          end
        end
      end

      ON: begin
        if (bus.annul) begin
          state_d  = IDLE;
          ready_d  = 1'b0;
          result_d = {(2*DATA_W){1'b0}};
        end else begin
          work_d    = step_s;
          counter_d = counter_q + CNT_W'(1);
          if (counter_d == CNT_LAST) begin
            state_d  = END;
            ready_d  = 1'b1;
            result_d = {apply_sign(rem_fin_s, rem_neg_q), apply_sign(quot_fin_s, quot_neg_q)};
          end else begin
            state_d = ON;
          end
        end
      end

      END: begin
        if (bus.annul || !bus.start) begin
          state_d  = IDLE;
          ready_d  = 1'b0;
          result_d = {(2*DATA_W){1'b0}};
        end else begin
          state_d = END;
        end
      end

      default: begin
        state_d  = IDLE;
        ready_d  = 1'b0;
        result_d = {(2*DATA_W){1'b0}};
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= IDLE;
      counter_q  <= {CNT_W{1'b0}};
      work_q     <= {(2*DATA_W+1){1'b0}};
      divisor_q  <= {DATA_W{1'b0}};
      quot_neg_q <= 1'b0;
      rem_neg_q  <= 1'b0;
      early_q    <= 1'b0;
      result_q   <= {(2*DATA_W){1'b0}};
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      counter_q  <= counter_d;
      work_q     <= work_d;
      divisor_q  <= divisor_d;
      quot_neg_q <= quot_neg_d;
      rem_neg_q  <= rem_neg_d;
      early_q    <= early_d;
      result_q   <= result_d;
      ready_q    <= ready_d;
    end
  end

  assign bus.result   = result_q;
  assign bus.ready    = ready_q;
  // Combinational so the pipeline freezes in the same cycle the request appears.
  assign bus.stallreq = resetn & bus.start & ~bus.annul & ~ready_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed test-plan cases plus randomized
// divisions checked against an arithmetic reference model.
module tb_div_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  logic resetn;
  int   checks = 0;
  int   errors = 0;

  div_if #(.DATA_W(W)) bif ();

  div_unit #(.DATA_W(W), .CNT_W(6)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bif.slave)
  );

  always #5 clk = ~clk;

  // Reference quotient/remainder from plain arithmetic (truncating division).
  function automatic logic [63:0] ref_div(input bit sd, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'h0;
    if (!sd) return {a % b, a / b};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    q  = sa / sb;
    r  = sa - q * sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Expected cycles from start sampled (cycle N) to ready high.
  function automatic int ref_lat(input bit sd, input logic [31:0] a, input logic [31:0] b);
    longint ma, mb;
    ma = (sd && a[31]) ? -longint'($signed(a)) : longint'(a);
    mb = (sd && b[31]) ? -longint'($signed(b)) : longint'(b);
    if (b == 32'd0) return 2;
`ifdef DIV_EARLY_OUT_EN
    if (ma < mb) return 2;
`else
    if (ma < mb) return 33;
`endif
    return 33;
  endfunction

  // Drives one division and reports what the DUT did; no checking here.
  task automatic do_div(input bit sd, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [63:0] res, output int stall_bad,
                        output logic stall_at_ready, output logic [63:0] res_hold,
                        output logic rdy_drop, output logic [63:0] res_drop);
    @(posedge clk); #1;
    bif.signed_div = sd; bif.opdata1 = a; bif.opdata2 = b;
    bif.start = 1'b1; bif.annul = 1'b0;
    lat = -1; stall_bad = 0;
    for (int k = 0; k <= 40; k++) begin
      @(negedge clk);
      if (bif.ready === 1'b1) begin
        lat = k;
        break;
      end
      if (bif.stallreq !== 1'b1) stall_bad++;
      if (k == 1) begin
        bif.opdata1 = $urandom;
        bif.opdata2 = $urandom;
      end
    end
    res = bif.result;
    stall_at_ready = bif.stallreq;
    @(negedge clk);
    res_hold = bif.result;
    @(posedge clk); #1;
    bif.start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rdy_drop = bif.ready;
    res_drop = bif.result;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    bif.start = 1'b1; bif.annul = 1'b0; bif.signed_div = 1'b0;
    bif.opdata1 = 32'd100; bif.opdata2 = 32'd7;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (bif.ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", bif.ready); end
    checks++; if (bif.result !== 64'h0) begin errors++; $display("FAIL reset_result got %h want 0", bif.result); end
    checks++; if (bif.stallreq !== 1'b0) begin errors++; $display("FAIL reset_stallreq got %b want 0", bif.stallreq); end
    @(posedge clk); #1;
    resetn = 1'b1; bif.start = 1'b0;
    @(negedge clk);
    checks++; if (bif.ready !== 1'b0) begin errors++; $display("FAIL post_reset_ready got %b want 0", bif.ready); end
  endtask

  task automatic test_directed();
    bit          sd_v [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [31:0] a_v  [7] = '{32'd100, 32'hFFFF_FFF9, 32'd7, 32'd5, 32'h8000_0000, 32'd3, 32'd9};
    logic [31:0] b_v  [7] = '{32'd7, 32'd2, 32'hFFFF_FFFE, 32'd0, 32'hFFFF_FFFF, 32'd10, 32'd3};
    logic [63:0] e_v  [7] = '{64'h0000_0002_0000_000E, 64'hFFFF_FFFF_FFFF_FFFD,
                              64'h0000_0001_FFFF_FFFD, 64'h0,
                              64'h0000_0000_8000_0000, 64'h0000_0003_0000_0000,
                              64'h0000_0000_0000_0003};
    int          l_v  [7] = '{33, 33, 33, 2, 33, 33, 33};
    int lat, sb;
    logic [63:0] res, rh, rd;
    logic sr, rdy;
`ifdef DIV_EARLY_OUT_EN
    l_v[5] = 2;
`endif
    for (int i = 0; i < 7; i++) begin
      do_div(sd_v[i], a_v[i], b_v[i], lat, res, sb, sr, rh, rdy, rd);
      checks++; if (res !== e_v[i]) begin errors++; $display("FAIL dir%0d_result got %h want %h", i, res, e_v[i]); end
      checks++; if (lat !== l_v[i]) begin errors++; $display("FAIL dir%0d_latency got %0d want %0d", i, lat, l_v[i]); end
      checks++; if (sb !== 0) begin errors++; $display("FAIL dir%0d_stall_low_cycles got %0d want 0", i, sb); end
      checks++; if (sr !== 1'b0) begin errors++; $display("FAIL dir%0d_stall_at_ready got %b want 0", i, sr); end
      checks++; if (rh !== e_v[i]) begin errors++; $display("FAIL dir%0d_result_hold got %h want %h", i, rh, e_v[i]); end
      checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL dir%0d_ready_after_drop got %b want 0", i, rdy); end
      checks++; if (rd !== 64'h0) begin errors++; $display("FAIL dir%0d_result_after_drop got %h want 0", i, rd); end
    end
  endtask

  task automatic test_annul();
    bit seen;
    int lat, sb;
    logic [63:0] res, rh, rd;
    logic sr, rdy;
    @(posedge clk); #1;
    bif.signed_div = 1'b0; bif.opdata1 = 32'd1000; bif.opdata2 = 32'd3;
    bif.start = 1'b1; bif.annul = 1'b0;
    repeat (10) @(posedge clk);
    #1 bif.annul = 1'b1;
    @(negedge clk);
    checks++; if (bif.stallreq !== 1'b0) begin errors++; $display("FAIL annul_stallreq got %b want 0", bif.stallreq); end
    checks++; if (bif.ready !== 1'b0) begin errors++; $display("FAIL annul_ready got %b want 0", bif.ready); end
    @(posedge clk); #1;
    bif.start = 1'b0; bif.annul = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bif.ready !== 1'b0) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL annul_ready_never got %b want 0", seen); end
    do_div(1'b0, 32'd9, 32'd3, lat, res, sb, sr, rh, rdy, rd);
    checks++; if (lat !== 33) begin errors++; $display("FAIL annul_next_latency got %0d want 33", lat); end
    checks++; if (res !== 64'h3) begin errors++; $display("FAIL annul_next_result got %h want 3", res); end
  endtask

  task automatic test_reset_mid();
    bit seen;
    int lat, sb;
    logic [63:0] res, rh, rd;
    logic sr, rdy;
    @(posedge clk); #1;
    bif.signed_div = 1'b0; bif.opdata1 = 32'd1000; bif.opdata2 = 32'd3;
    bif.start = 1'b1; bif.annul = 1'b0;
    repeat (15) @(posedge clk);
    #1 resetn = 1'b0;
    @(negedge clk);
    checks++; if (bif.stallreq !== 1'b0) begin errors++; $display("FAIL midreset_stallreq got %b want 0", bif.stallreq); end
    @(posedge clk); #1;
    resetn = 1'b1; bif.start = 1'b0;
    @(negedge clk);
    checks++; if (bif.ready !== 1'b0) begin errors++; $display("FAIL midreset_ready got %b want 0", bif.ready); end
    checks++; if (bif.result !== 64'h0) begin errors++; $display("FAIL midreset_result got %h want 0", bif.result); end
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bif.ready !== 1'b0) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midreset_ready_never got %b want 0", seen); end
    do_div(1'b0, 32'd9, 32'd3, lat, res, sb, sr, rh, rdy, rd);
    checks++; if (res !== 64'h3) begin errors++; $display("FAIL midreset_next_result got %h want 3", res); end
    checks++; if (lat !== 33) begin errors++; $display("FAIL midreset_next_latency got %0d want 33", lat); end
  endtask

  task automatic test_random_back_to_back();
    int lat, sb, el;
    logic [63:0] res, rh, rd, exp;
    logic sr, rdy;
    bit sd;
    logic [31:0] a, b;
    for (int i = 0; i < 30; i++) begin
      sd = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 20)) : 32'($urandom);
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFF : 32'h8000_0000;
        default: b = 32'($urandom);
      endcase
      exp = ref_div(sd, a, b);
      el  = ref_lat(sd, a, b);
      do_div(sd, a, b, lat, res, sb, sr, rh, rdy, rd);
      checks++; if (res !== exp) begin errors++; $display("FAIL rnd%0d_result sd=%0d a=%h b=%h got %h want %h", i, sd, a, b, res, exp); end
      checks++; if (lat !== el) begin errors++; $display("FAIL rnd%0d_latency got %0d want %0d", i, lat, el); end
      checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL rnd%0d_ready_after_drop got %b want 0", i, rdy); end
    end
  endtask

  initial begin
    resetn = 1'b0;
    bif.start = 1'b0; bif.annul = 1'b0; bif.signed_div = 1'b0;
    bif.opdata1 = 32'd0; bif.opdata2 = 32'd0;
    test_reset();
    test_directed();
    test_annul();
    test_reset_mid();
    test_random_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
